// File: rtl/ex_pkg.sv
// ex_pkg: constants shared by the execute stage and its ALU.
//   ALU_*  : 3-bit ALU operation codes carried in the ID/EX bundle.
//   DST_*  : 2-bit destination-register select codes.
//   RA_IDX : register index used as the jal link register.
package ex_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam int RA_IDX = 31;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: purely combinational ALU of the execute stage.
//   op     in  3    : operation code (ex_pkg::ALU_*)
//   a, b   in  XLEN : operands
//   result out XLEN : AND/OR/ADD/SUB (wrapping), SLT (signed, 0/1); other codes give 0
//   zero   out 1    : result == 0
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline, including the
// EX/MEM pipeline register.
// Build option: define EX_FWD_EN to enable operand forwarding from EX/MEM and
// MEM/WB. Without it operands come straight from read_data1/read_data2 and the
// wb_* inputs are ignored (the hazard unit must then stall on RAW hazards).
// Ports:
//   clk, rst (async, active-low)
//   ID/EX bundle : alu_function, alu_src, reg_write, mem_read, mem_write,
//                  reg_dst, mem_to_reg, read_data1, read_data2, sign_extend,
//                  addPC, rs, rt, rd
//   MEM/WB fwd   : wb_reg_write, wb_write_reg, wb_data
//   hazard       : stall (hold EX/MEM), flush (bubble controls; beats stall)
//   EX/MEM out   : alu_result_out, write_data_out, addPC_out, write_reg_out,
//                  zero_out, reg_write_out, mem_read_out, mem_write_out,
//                  mem_to_reg_out
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RLEN = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      alu_function,
    input  logic            alu_src,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      reg_dst,
    input  logic [1:0]      mem_to_reg,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] sign_extend,
    input  logic [XLEN-1:0] addPC,
    input  logic [RLEN-1:0] rs,
    input  logic [RLEN-1:0] rt,
    input  logic [RLEN-1:0] rd,
    input  logic            wb_reg_write,
    input  logic [RLEN-1:0] wb_write_reg,
    input  logic [XLEN-1:0] wb_data,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] write_data_out,
    output logic [XLEN-1:0] addPC_out,
    output logic [RLEN-1:0] write_reg_out,
    output logic            zero_out,
    output logic            reg_write_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic [1:0]      mem_to_reg_out
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;
    logic [RLEN-1:0] write_reg;

    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic [XLEN-1:0] add_pc_q, add_pc_d;
    logic [RLEN-1:0] write_reg_q, write_reg_d;
    logic            zero_q, zero_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic [1:0]      mem_to_reg_q, mem_to_reg_d;

`ifdef EX_FWD_EN
    // EX/MEM is the younger producer, so it is checked first. Register 0 is
    // hard-wired to zero and must never be forwarded.
    logic exm_hit_a, exm_hit_b, wb_hit_a, wb_hit_b;

    always_comb begin
        exm_hit_a = reg_write_q && (write_reg_q != '0) && (write_reg_q == rs);
        exm_hit_b = reg_write_q && (write_reg_q != '0) && (write_reg_q == rt);
        wb_hit_a  = wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == rs);
        wb_hit_b  = wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == rt);

        op_a = read_data1;
        if (exm_hit_a)     op_a = alu_result_q;
        else if (wb_hit_a) op_a = wb_data;

        rt_val = read_data2;
        if (exm_hit_b)     rt_val = alu_result_q;
        else if (wb_hit_b) rt_val = wb_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_reg_write, wb_write_reg, wb_data, rs};

    always_comb begin
        op_a   = read_data1;
        rt_val = read_data2;
    end
`endif

    assign op_b = alu_src ? sign_extend : rt_val;

    ex_alu #(.XLEN(XLEN)) u_alu (
        .op     (alu_function),
        .a      (op_a),
        .b      (op_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_comb begin
        write_reg = '0;
        unique case (reg_dst)
            DST_RT:  write_reg = rt;
            DST_RD:  write_reg = rd;
            DST_RA:  write_reg = RLEN'(RA_IDX);
            default: write_reg = '0;
        endcase
    end

    // Flush takes priority over stall: data still loads, controls become a bubble.
    always_comb begin
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        add_pc_d     = add_pc_q;
        write_reg_d  = write_reg_q;
        zero_d       = zero_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (flush || !stall) begin
            alu_result_d = alu_res;
            write_data_d = rt_val;
            add_pc_d     = addPC;
            write_reg_d  = write_reg;
            zero_d       = alu_zero;
            reg_write_d  = flush ? 1'b0 : reg_write;
            mem_read_d   = flush ? 1'b0 : mem_read;
            mem_write_d  = flush ? 1'b0 : mem_write;
            mem_to_reg_d = flush ? 2'b00 : mem_to_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            add_pc_q     <= '0;
            write_reg_q  <= '0;
            zero_q       <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 2'b00;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            add_pc_q     <= add_pc_d;
            write_reg_q  <= write_reg_d;
            zero_q       <= zero_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign alu_result_out = alu_result_q;
    assign write_data_out = write_data_q;
    assign addPC_out      = add_pc_q;
    assign write_reg_out  = write_reg_q;
    assign zero_out       = zero_q;
    assign reg_write_out  = reg_write_q;
    assign mem_read_out   = mem_read_q;
    assign mem_write_out  = mem_write_q;
    assign mem_to_reg_out = mem_to_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed testbench for ex_stage. Expected values are hand
// computed; where forwarding matters the expectation depends on EX_FWD_EN.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alu_function;
    logic        alu_src, reg_write, mem_read, mem_write;
    logic [1:0]  reg_dst, mem_to_reg;
    logic [31:0] read_data1, read_data2, sign_extend, addPC;
    logic [4:0]  rs, rt, rd;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_data;
    logic        stall, flush;
    logic [31:0] alu_result_out, write_data_out, addPC_out;
    logic [4:0]  write_reg_out;
    logic        zero_out, reg_write_out, mem_read_out, mem_write_out;
    logic [1:0]  mem_to_reg_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32), .RLEN(5)) dut (
        .clk(clk), .rst(rst),
        .alu_function(alu_function), .alu_src(alu_src),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .read_data1(read_data1), .read_data2(read_data2),
        .sign_extend(sign_extend), .addPC(addPC),
        .rs(rs), .rt(rt), .rd(rd),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_data(wb_data),
        .stall(stall), .flush(flush),
        .alu_result_out(alu_result_out), .write_data_out(write_data_out),
        .addPC_out(addPC_out), .write_reg_out(write_reg_out),
        .zero_out(zero_out), .reg_write_out(reg_write_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .mem_to_reg_out(mem_to_reg_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] f, input logic src, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                          input logic [1:0] dst, input logic rw);
        alu_function = f; alu_src = src; read_data1 = a; read_data2 = b;
        sign_extend = imm; rs = s; rt = t; rd = d; reg_dst = dst; reg_write = rw;
    endtask

    initial begin
        rst = 1'b0;
        set_op(3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
        mem_read = 0; mem_write = 0; mem_to_reg = 0; addPC = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_data = 0; stall = 0; flush = 0;

        // Reset state
        #12;
        check("rst_result", alu_result_out, 32'h0);
        check("rst_write_reg", {27'd0, write_reg_out}, 32'h0);
        check("rst_reg_write", {31'd0, reg_write_out}, 32'h0);
        rst = 1'b1;

        // ADD with immediate: 5 + (-3) = 2
        set_op(3'b010, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFD, 5'd1, 5'd2, 5'd3, 2'b01, 1'b1);
        tick();
        check("add_imm_result", alu_result_out, 32'd2);
        check("add_imm_zero", {31'd0, zero_out}, 32'd0);
        check("add_imm_dst", {27'd0, write_reg_out}, 32'd3);
        check("add_imm_rw", {31'd0, reg_write_out}, 32'd1);

        // SUB 7 - 7 = 0
        set_op(3'b110, 1'b0, 32'd7, 32'd7, 32'd0, 5'd4, 5'd5, 5'd6, 2'b00, 1'b1);
        tick();
        check("sub_result", alu_result_out, 32'd0);
        check("sub_zero", {31'd0, zero_out}, 32'd1);
        check("sub_dst_rt", {27'd0, write_reg_out}, 32'd5);
        check("sub_wdata", write_data_out, 32'd7);

        // Back-to-back dependency through r8
        set_op(3'b010, 1'b0, 32'd3, 32'd4, 32'd0, 5'd6, 5'd7, 5'd8, 2'b01, 1'b1);
        tick();
        check("b2b_prod", alu_result_out, 32'd7);
        set_op(3'b010, 1'b0, 32'd100, 32'd200, 32'd0, 5'd8, 5'd8, 5'd10, 2'b01, 1'b0);
        tick();
`ifdef EX_FWD_EN
        check("b2b_cons", alu_result_out, 32'd14);
        check("b2b_wdata", write_data_out, 32'd7);
`else
        check("b2b_cons", alu_result_out, 32'd300);
        check("b2b_wdata", write_data_out, 32'd200);
`endif

        // Double match on r9: EX/MEM=10, MEM/WB=20
        set_op(3'b010, 1'b1, 32'd10, 32'd0, 32'd0, 5'd1, 5'd2, 5'd9, 2'b01, 1'b1);
        tick();
        check("dbl_prod", alu_result_out, 32'd10);
        set_op(3'b010, 1'b1, 32'd55, 32'd0, 32'd0, 5'd9, 5'd2, 5'd0, 2'b01, 1'b0);
        wb_reg_write = 1; wb_write_reg = 5'd9; wb_data = 32'd20;
        tick();
`ifdef EX_FWD_EN
        check("dbl_cons", alu_result_out, 32'd10);
`else
        check("dbl_cons", alu_result_out, 32'd55);
`endif

        // Writes to r0 in both sources never forward
        set_op(3'b010, 1'b1, 32'd77, 32'd0, 32'd0, 5'd1, 5'd2, 5'd0, 2'b01, 1'b1);
        wb_reg_write = 0;
        tick();
        check("r0_prod", alu_result_out, 32'd77);
        set_op(3'b010, 1'b1, 32'd66, 32'd0, 32'd0, 5'd0, 5'd2, 5'd11, 2'b01, 1'b0);
        wb_reg_write = 1; wb_write_reg = 5'd0; wb_data = 32'd20;
        tick();
        check("r0_cons", alu_result_out, 32'd66);

        // MEM/WB-only forwarding on r12
        set_op(3'b010, 1'b1, 32'd1, 32'd0, 32'd0, 5'd12, 5'd2, 5'd11, 2'b01, 1'b0);
        wb_write_reg = 5'd12;
        tick();
`ifdef EX_FWD_EN
        check("wb_fwd", alu_result_out, 32'd20);
`else
        check("wb_fwd", alu_result_out, 32'd1);
`endif
        wb_reg_write = 0;

        // SLT signed, reg_dst=RA
        set_op(3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd13, 5'd14, 5'd15, 2'b10, 1'b0);
        addPC = 32'h0000_0400;
        tick();
        check("slt_neg", alu_result_out, 32'd1);
        check("slt_ra", {27'd0, write_reg_out}, 32'd31);
        check("slt_pc", addPC_out, 32'h0000_0400);
        set_op(3'b111, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd13, 5'd14, 5'd15, 2'b11, 1'b0);
        tick();
        check("slt_pos", alu_result_out, 32'd0);
        check("slt_zero", {31'd0, zero_out}, 32'd1);
        check("dst_11", {27'd0, write_reg_out}, 32'd0);

        // AND / OR / undefined code
        set_op(3'b000, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd13, 5'd14, 5'd15, 2'b00, 1'b0);
        tick();
        check("and", alu_result_out, 32'h0000_F000);
        alu_function = 3'b001;
        tick();
        check("or", alu_result_out, 32'h0000_FFF0);
        alu_function = 3'b011;
        tick();
        check("undef_op", alu_result_out, 32'h0);

        // Stall holds everything
        set_op(3'b010, 1'b1, 32'd1, 32'd0, 32'd2, 5'd15, 5'd21, 5'd20, 2'b01, 1'b1);
        mem_read = 1; mem_to_reg = 2'b10; addPC = 32'h0000_0800;
        tick();
        check("ld_result", alu_result_out, 32'd3);
        read_data1 = 32'd50; mem_read = 0; mem_to_reg = 0; reg_dst = 2'b00;
        addPC = 32'h0000_0900; stall = 1;
        tick();
        tick();
        check("stall_result", alu_result_out, 32'd3);
        check("stall_dst", {27'd0, write_reg_out}, 32'd20);
        check("stall_mread", {31'd0, mem_read_out}, 32'd1);
        check("stall_m2r", {30'd0, mem_to_reg_out}, 32'd2);
        check("stall_pc", addPC_out, 32'h0000_0800);

        // Flush beats stall: controls bubble, data loads
        flush = 1; mem_write = 1; reg_write = 1;
        tick();
        check("flush_mwrite", {31'd0, mem_write_out}, 32'd0);
        check("flush_rwrite", {31'd0, reg_write_out}, 32'd0);
        check("flush_result", alu_result_out, 32'd52);
        check("flush_dst", {27'd0, write_reg_out}, 32'd21);
        flush = 0; stall = 0;

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check("arst_result", alu_result_out, 32'h0);
        check("arst_dst", {27'd0, write_reg_out}, 32'h0);
        check("arst_pc", addPC_out, 32'h0);
        check("arst_wdata", write_data_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. It consumes the decoded bundle held in the ID/EX pipeline register and applies operand forwarding from the EX/MEM and MEM/WB stages. It executes the ALU operation, resolves the destination register and registers the result into the EX/MEM pipeline register, which lives inside this block. Stall and flush inputs come from the hazard unit.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `RLEN`, 5: register-index width.

Ports:
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `alu_function` in 3: ALU op from ID/EX.
- `alu_src` in 1: 1 selects `sign_extend` as operand B.
- `reg_write`, `mem_read`, `mem_write` in 1 each: ID/EX control.
- `reg_dst` in 2: destination select; 00 rt, 01 rd, 10 register 31.
- `mem_to_reg` in 2: passed through unchanged.
- `read_data1`, `read_data2`, `sign_extend`, `addPC` in XLEN: ID/EX data.
- `rs`, `rt`, `rd` in RLEN: ID/EX register indices.
- `wb_reg_write` in 1, `wb_write_reg` in RLEN, `wb_data` in XLEN: MEM/WB forwarding source.
- `stall` in 1: hold the EX/MEM register.
- `flush` in 1: load a bubble into EX/MEM.
- `alu_result_out`, `write_data_out`, `addPC_out` out XLEN: EX/MEM data.
- `write_reg_out` out RLEN: resolved destination.
- `zero_out` out 1: ALU result equals 0.
- `reg_write_out`, `mem_read_out`, `mem_write_out` out 1; `mem_to_reg_out` out 2: EX/MEM control.

## Operation
- Forwarding is resolved per operand for rs (A) and rt (B-reg), in priority order:
  - First, EX/MEM: `reg_write_out`=1, `write_reg_out`≠0 and equal to the index → `alu_result_out`.
  - Else MEM/WB: `wb_reg_write`=1, `wb_write_reg`≠0 and equal to the index → `wb_data`.
  - Else `read_data1` / `read_data2`.
- Operand B = `sign_extend` if `alu_src`, else the forwarded rt value.
- `write_data_out` always takes the forwarded rt value, so store data is forwarded too.
- ALU codes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB: modulo 2^XLEN, no overflow trap.
  - 111 SLT: signed compare, result 1 or 0 zero-extended.
  - Any other code: result 0.
- `zero_out` = (ALU result == 0).
- Destination: reg_dst 00 → rt, 01 → rd, 10 → 31, 11 → 0.
- `addPC_out` registers `addPC` for jal link data.

## Timing
- One-cycle latency: the ID/EX bundle present before edge N appears on outputs after edge N.
- Reset (`rst`=0) asynchronously clears every output to 0. The first capture happens on the first rising edge after release.
- `stall`=1, `flush`=0: all outputs hold their values, including forwarding from the held `alu_result_out`.
- `flush`=1: control outputs (`reg_write_out`, `mem_read_out`, `mem_write_out`, `mem_to_reg_out`) load 0. Data outputs load normally. Flush overrides stall.
- A write to register 0 never forwards.
- When EX/MEM and MEM/WB both match an index, EX/MEM wins.
- Forwarding paths are combinational from outputs and `wb_*` into the next capture; there are no extra cycles.

## Configuration
- `EX_FWD_EN` defined: forwarding as specified above.
- `EX_FWD_EN` undefined: operands are taken directly from `read_data1` / `read_data2`. The `wb_*` inputs are ignored, and the hazard unit must stall for RAW hazards. All other behaviour is unchanged.

## Structure
- Package `ex_pkg` holds:
  - ALU op constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`.
  - reg_dst constants `DST_RT`, `DST_RD`, `DST_RA`.
  - Constant `RA_IDX` = 31.
- One sub-module, `ex_alu`: a combinational ALU taking op, a, b and producing result and zero.
- Forwarding muxes and the EX/MEM register stay in `ex_stage`.

## Test plan
- Reset mid-run: drive outputs non-zero, pull `rst` low between edges → all outputs 0 immediately, before the next edge.
- ADD with `alu_src`=1, read_data1=5, sign_extend=0xFFFFFFFD → `alu_result_out`=2, `zero_out`=0. Then SUB 7-7 → result 0, `zero_out`=1.
- Back-to-back dependency: cycle 1 writes rd=8 with ADD 3+4; cycle 2 uses rs=8, rt=8, ADD → 14, with EX/MEM forwarding on both operands.
- Double match: EX/MEM writes r9=10 and MEM/WB writes r9=20; consumer rs=9, ADD with imm 0 → 10. With write_reg=0 in both sources → raw `read_data1` is used.
- SLT signed: a=0xFFFFFFFF, b=1 → 1; a=1, b=0xFFFFFFFF → 0. reg_dst=10 → `write_reg_out`=31 and `addPC_out`=`addPC`.
- Stall/flush:
  - `stall`=1 for 2 cycles → outputs hold.
  - `stall`=1 with `flush`=1 and mem_write=1 → `mem_write_out`=0, `reg_write_out`=0.
  - Build without `EX_FWD_EN` → back-to-back case yields `read_data1`-based result.
